sp_reader: RTL and testbench

- Read-side consumer of the scratchpad result memory in the matrix-multiply accelerator.
- On request, drives the scratchpad's streaming read interface (`start_send` / `mode` / `read_target`) for one target.
- Captures one full result matrix (MAX_DIM*MAX_DIM words) into a local buffer, then drains it element by element over a valid/ready handshake toward the host/bus side.
- Checks the scratchpad's finish flag at end of fetch.

---
 rtl/sp_reader.sv | 181 ++++++++++++++++++
 tb/tb_sp_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_reader.sv
// ---------------------------------------------------------------------------
// sp_reader
//
// Read-side consumer of the scratchpad result memory. On request it streams
// one full result matrix (NWORDS words) out of the scratchpad for a single
// target into a local buffer. It then hands the elements to the host side
// one by one over a valid/ready handshake, tagged with their row and column.
//
// Ports
//   clk_i             clock, rising edge
//   rst_i             synchronous active-high reset
//   req_i, target_i   start a read of one target (accepted only in IDLE)
//   sp_data_i         scratchpad read data (follows its internal counter)
//   sp_finish_i       scratchpad "finished sending" flag (checked only)
//   sp_start_send_o   advances the scratchpad read counter each cycle high
//   sp_mode_o         scratchpad mode select (1 = read)
//   sp_read_target_o  target being read
//   elem_valid_o / elem_ready_i / elem_data_o / elem_row_o / elem_col_o
//                     element output stream
//   busy_o            high while fetching or draining
//   done_o            one-cycle pulse after the last element handshake
//   err_o             sticky: scratchpad had not finished at end of fetch
// ---------------------------------------------------------------------------
module sp_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int BUS_WIDTH   = 64,
    parameter int SP_NTARGETS = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        req_i,
    input  logic [$clog2(SP_NTARGETS)-1:0]              target_i,
    input  logic [BUS_WIDTH-1:0]                        sp_data_i,
    input  logic                                        sp_finish_i,
    output logic                                        sp_start_send_o,
    output logic                                        sp_mode_o,
    output logic [$clog2(SP_NTARGETS)-1:0]              sp_read_target_o,
    output logic                                        elem_valid_o,
    input  logic                                        elem_ready_i,
    output logic [BUS_WIDTH-1:0]                        elem_data_o,
    output logic [$clog2(BUS_WIDTH/DATA_WIDTH)-1:0]     elem_row_o,
    output logic [$clog2(BUS_WIDTH/DATA_WIDTH)-1:0]     elem_col_o,
    output logic                                        busy_o,
    output logic                                        done_o,
    output logic                                        err_o
);

    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int NWORDS  = MAX_DIM * MAX_DIM;
    localparam int RW      = $clog2(MAX_DIM);
    localparam int AW      = 2 * RW;
    localparam int TW      = $clog2(SP_NTARGETS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [AW-1:0]        cnt_reg;
    logic [TW-1:0]        target_reg;
    logic                 err_reg;
    logic                 first_reg;   // high during the first DRAIN cycle only
    logic [BUS_WIDTH-1:0] data_reg;    // registered read port of the buffer
    logic [BUS_WIDTH-1:0] buf_mem [NWORDS];

    logic last_word;
    assign last_word = (cnt_reg == AW'(NWORDS - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_i) state_next = FETCH;
            FETCH:   if (last_word) state_next = DRAIN;
            DRAIN:   if (elem_ready_i && last_word) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- capture buffer (no reset: contents are don't-care) ----
    always_ff @(posedge clk_i) begin
        if (state_reg == FETCH) begin
            buf_mem[cnt_reg] <= sp_data_i;
        end
    end

    // ---------------- datapath / counters ----------------
    // The buffer is read through data_reg, so the next element is fetched one
    // edge ahead: word 0 at the FETCH->DRAIN edge (already written by then),
    // word cnt+1 on every non-final handshake. data_reg therefore holds still
    // while valid is high and ready is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg    <= '0;
            target_reg <= '0;
            err_reg    <= 1'b0;
            first_reg  <= 1'b0;
            data_reg   <= '0;
        end else begin
            first_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_i) begin
                        target_reg <= target_i;
                        err_reg    <= 1'b0;
                        cnt_reg    <= '0;
                    end
                end
                FETCH: begin
                    // NWORDS is a power of two, so the increment wraps to 0
                    // exactly when fetch ends and drain starts at word 0.
                    cnt_reg <= cnt_reg + AW'(1);
                    if (last_word) begin
                        first_reg <= 1'b1;
                        data_reg  <= buf_mem[0];
                    end
                end
                DRAIN: begin
                    if (first_reg && !sp_finish_i) begin
                        err_reg <= 1'b1;
                    end
                    if (elem_ready_i) begin
                        cnt_reg <= cnt_reg + AW'(1);
                        if (!last_word) begin
                            data_reg <= buf_mem[cnt_reg + AW'(1)];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        sp_start_send_o  = 1'b0;
        sp_mode_o        = 1'b0;
        sp_read_target_o = '0;
        elem_valid_o     = 1'b0;
        elem_data_o      = '0;
        elem_row_o       = '0;
        elem_col_o       = '0;
        busy_o           = 1'b0;
        done_o           = 1'b0;
        case (state_reg)
            FETCH: begin
                sp_start_send_o  = 1'b1;
                sp_mode_o        = 1'b1;
                sp_read_target_o = target_reg;
                busy_o           = 1'b1;
            end
            DRAIN: begin
                elem_valid_o = 1'b1;
                elem_data_o  = data_reg;
                elem_row_o   = cnt_reg[AW-1:RW];
                elem_col_o   = cnt_reg[RW-1:0];
                busy_o       = 1'b1;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign err_o = err_reg;

endmodule

// File: tb/tb_sp_reader.sv
// ---------------------------------------------------------------------------
// tb_sp_reader
//
// Directed bench for sp_reader with a small scratchpad model: a per-target
// word table, a read counter advanced by start_send, and a sticky finish
// flag set on the counter's first wrap (overridable to 0).
// ---------------------------------------------------------------------------
module tb_sp_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [1:0]  target;
    logic [63:0] sp_data;
    logic        sp_finish;
    logic        start_send;
    logic        mode;
    logic [1:0]  read_target;
    logic        valid;
    logic        ready;
    logic [63:0] data;
    logic [0:0]  row;
    logic [0:0]  col;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    sp_reader dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .target_i         (target),
        .sp_data_i        (sp_data),
        .sp_finish_i      (sp_finish),
        .sp_start_send_o  (start_send),
        .sp_mode_o        (mode),
        .sp_read_target_o (read_target),
        .elem_valid_o     (valid),
        .elem_ready_i     (ready),
        .elem_data_o      (data),
        .elem_row_o       (row),
        .elem_col_o       (col),
        .busy_o           (busy),
        .done_o           (done),
        .err_o            (err)
    );

    // ---------------- scratchpad model ----------------
    logic [63:0] sp_mem [4][4];
    logic [1:0]  sp_addr;
    logic        sp_wrapped;
    logic        force_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_addr    <= 2'd0;
            sp_wrapped <= 1'b0;
        end else if (start_send) begin
            sp_addr <= sp_addr + 2'd1;
            if (sp_addr == 2'd3) sp_wrapped <= 1'b1;
        end
    end
    assign sp_data   = sp_mem[read_target][sp_addr];
    assign sp_finish = sp_wrapped & ~force_zero;

    // ---------------- bookkeeping ----------------
    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] got_data [8];
    int          got_row  [8];
    int          got_col  [8];
    int r_ss, r_badtgt, r_badmode, r_nelem, r_done_cyc, r_done_cnt;
    int r_err_first, r_hold22;
    logic r_err_done, r_err_c1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete read. Called in IDLE, #1 after an edge; returns a few
    // cycles after done (or after the cycle budget if done never comes).
    task automatic do_read(input logic [1:0] tgt, input int stall_len, input bit inject);
        int stall_left;
        stall_left  = stall_len;
        r_ss = 0; r_badtgt = 0; r_badmode = 0; r_nelem = 0;
        r_done_cyc = -1; r_done_cnt = 0; r_err_first = -1; r_hold22 = 0;
        r_err_done = 1'bx; r_err_c1 = 1'bx;
        target = tgt;
        req    = 1'b1;
        ready  = 1'b1;
        step();
        req = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (inject) begin
                req    = (cyc == 2 || cyc == 6);
                target = 2'd1;
            end
            ready = 1'b1;
            if (r_nelem == 1 && stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end
            if (cyc == 1) r_err_c1 = err;
            if (err && r_err_first < 0) r_err_first = cyc;
            if (start_send) begin
                r_ss++;
                if (read_target != tgt) r_badtgt++;
            end
            if (mode != start_send) r_badmode++;
            if (valid && data == 64'h22) r_hold22++;
            if (valid && ready) begin
                if (r_nelem < 8) begin
                    got_data[r_nelem] = data;
                    got_row[r_nelem]  = int'(row);
                    got_col[r_nelem]  = int'(col);
                end
                r_nelem++;
            end
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) begin
                    r_done_cyc = cyc;
                    r_err_done = err;
                end
            end
            if (r_done_cyc > 0 && cyc >= r_done_cyc + 3) break;
            step();
        end
        req   = 1'b0;
        ready = 1'b1;
    endtask

    task automatic check_elems(input string tag, input logic [1:0] tgt);
        check({tag, "_nelem"}, 64'(r_nelem), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_data%0d", tag, i), got_data[i], sp_mem[tgt][i]);
            check($sformatf("%s_row%0d", tag, i), 64'(got_row[i]), 64'(i / 2));
            check($sformatf("%s_col%0d", tag, i), 64'(got_col[i]), 64'(i % 2));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_start_send"}, 64'(start_send), 64'd0);
        check({tag, "_mode"},       64'(mode),       64'd0);
        check({tag, "_rtarget"},    64'(read_target), 64'd0);
        check({tag, "_valid"},      64'(valid),      64'd0);
        check({tag, "_data"},       data,            64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_done"},       64'(done),       64'd0);
        check({tag, "_err"},        64'(err),        64'd0);
    endtask

    initial begin
        for (int t = 0; t < 4; t++)
            for (int w = 0; w < 4; w++)
                sp_mem[t][w] = 64'hC0DE_0000_0000_0000 | 64'(t * 16 + w);
        sp_mem[2][0] = 64'h11;
        sp_mem[2][1] = 64'h22;
        sp_mem[2][2] = 64'h33;
        sp_mem[2][3] = 64'h44;

        rst = 1'b1; req = 1'b0; target = 2'd0; ready = 1'b0; force_zero = 1'b0;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("idle");

        // Basic drain: target 2, ready high
        do_read(2'd2, 0, 1'b0);
        check("basic_ss_cycles", 64'(r_ss), 64'd4);
        check("basic_bad_target", 64'(r_badtgt), 64'd0);
        check("basic_bad_mode", 64'(r_badmode), 64'd0);
        check_elems("basic", 2'd2);
        check("basic_done_cycle", 64'(r_done_cyc), 64'd9);
        check("basic_done_count", 64'(r_done_cnt), 64'd1);
        check("basic_err", 64'(r_err_done), 64'd0);

        // Backpressure: ready low 3 cycles on element 1
        do_read(2'd2, 3, 1'b0);
        check_elems("bp", 2'd2);
        check("bp_hold_0x22", 64'(r_hold22), 64'd4);
        check("bp_done_cycle", 64'(r_done_cyc), 64'd12);
        check("bp_done_count", 64'(r_done_cnt), 64'd1);

        // Back-to-back: target 0 then target 3, no scratchpad reset
        do_read(2'd0, 0, 1'b0);
        check_elems("b2b_t0", 2'd0);
        check("b2b_t0_err", 64'(r_err_done), 64'd0);
        do_read(2'd3, 0, 1'b0);
        check_elems("b2b_t3", 2'd3);
        check("b2b_t3_err", 64'(r_err_done), 64'd0);
        check("b2b_t3_ss_cycles", 64'(r_ss), 64'd4);

        // Error flag: finish held low at end of fetch
        force_zero = 1'b1;
        do_read(2'd1, 0, 1'b0);
        force_zero = 1'b0;
        check("err_first_cycle", 64'(r_err_first), 64'd6);
        check("err_at_done", 64'(r_err_done), 64'd1);
        check("err_done_cycle", 64'(r_done_cyc), 64'd9);
        check_elems("err", 2'd1);
        check("err_sticky_idle", 64'(err), 64'd1);
        do_read(2'd2, 0, 1'b0);
        check("err_cleared_on_accept", 64'(r_err_c1), 64'd0);
        check("err_next_read_clean", 64'(r_err_done), 64'd0);

        // Ignored requests during FETCH and DRAIN
        do_read(2'd2, 0, 1'b1);
        check("ign_bad_target", 64'(r_badtgt), 64'd0);
        check("ign_ss_cycles", 64'(r_ss), 64'd4);
        check("ign_done_count", 64'(r_done_cnt), 64'd1);
        check("ign_done_cycle", 64'(r_done_cyc), 64'd9);
        check_elems("ign", 2'd2);

        // Reset mid-fetch (scratchpad reset together with the reader)
        target = 2'd3;
        req    = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        check("rstmid_fetching", 64'(start_send), 64'd1);
        rst = 1'b1;
        step();
        check_idle("rstmid");
        rst = 1'b0;
        step();
        do_read(2'd1, 0, 1'b0);
        check_elems("rstmid_fresh", 2'd1);
        check("rstmid_fresh_ss", 64'(r_ss), 64'd4);
        check("rstmid_fresh_done", 64'(r_done_cyc), 64'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
